cla_nl_combine: RTL and testbench

//  Stage that sits directly downstream of the CLA non-linear term generator. It takes the

---
 rtl/cla_nl_combine_if.sv | 32 +++
 rtl/cla_nl_combine.sv | 91 +++++++++
 tb/tb_cla_nl_combine.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_nl_combine_if.sv
// Handshake bundle between the CLA term generator, the combine stage and its consumer.
// The master side drives operands, terms, out_ready and clr; the slave side is the combine stage.
interface cla_nl_combine_if #(
  parameter int NBIT  = 4,
  parameter int NNL   = 56,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NBIT-1:0]  a;
  logic [NBIT-1:0]  b;
  logic             c;
  logic [NNL-1:0]   n;
  logic             out_valid;
  logic             out_ready;
  logic [NBIT-1:0]  sum;
  logic             cout;
  logic             mismatch;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic             clr;

  modport master (
    output in_valid, a, b, c, n, out_ready, clr,
    input  in_ready, out_valid, sum, cout, mismatch, err_sticky, err_cnt
  );

  modport slave (
    input  in_valid, a, b, c, n, out_ready, clr,
    output in_ready, out_valid, sum, cout, mismatch, err_sticky, err_cnt
  );
endinterface

// File: rtl/cla_nl_combine.sv
// Two-stage combine: XOR-reduces the generator's non-linear terms into carries, forms sum/cout,
// and checks each result against a+b+c, keeping a sticky flag and a saturating mismatch count.
module cla_nl_combine #(
  parameter int NBIT  = 4,
  parameter int NNL   = 56,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  cla_nl_combine_if.slave  bus
);
  logic            s1_v;
  logic [NBIT-1:0] s1_a;
  logic [NBIT-1:0] s1_b;
  logic            s1_c;
  logic [NNL-1:0]  s1_n;

  logic            adv1;
  logic            adv2;
  logic            deliver;
  logic [NBIT:0]   carry;
  logic [NBIT-1:0] sum_c;
  logic [NBIT:0]   ref_v;
  logic            mm_c;

  assign adv2        = !bus.out_valid || bus.out_ready;
  assign adv1        = !s1_v || adv2;
  assign bus.in_ready = adv1;
  assign deliver     = bus.out_valid && bus.out_ready && bus.mismatch;

  // Block j holds the GF(2) terms of carry j+1; their parity is the carry itself.
  assign carry[0] = s1_c;
  for (genvar j = 0; j < NBIT; j++) begin : g_blk
    localparam int OFF = 2**(j+2) - 4 - j;
    localparam int SZ  = 2**(j+2) - 1;
    assign carry[j+1] = ^s1_n[OFF +: SZ];
  end

  assign sum_c = s1_a ^ s1_b ^ carry[NBIT-1:0];
  assign ref_v = {1'b0, s1_a} + {1'b0, s1_b} + {{NBIT{1'b0}}, s1_c};
  assign mm_c  = ({carry[NBIT], sum_c} != ref_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_c <= 1'b0;
      s1_n <= '0;
    end else if (adv1) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a <= bus.a;
        s1_b <= bus.b;
        s1_c <= bus.c;
        s1_n <= bus.n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.mismatch  <= 1'b0;
    end else if (adv2) begin
      bus.out_valid <= s1_v;
      if (s1_v) begin
        bus.sum      <= sum_c;
        bus.cout     <= carry[NBIT];
        bus.mismatch <= mm_c;
      end
    end
  end

  // clr wins over a same-cycle delivery, so that mismatch is dropped from the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_sticky <= 1'b0;
      bus.err_cnt    <= '0;
    end else if (bus.clr) begin
      bus.err_sticky <= 1'b0;
      bus.err_cnt    <= '0;
    end else if (deliver) begin
      bus.err_sticky <= 1'b1;
      if (bus.err_cnt != {CNT_W{1'b1}})
        bus.err_cnt <= bus.err_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cla_nl_combine.sv
// Bench for cla_nl_combine: builds genuine carry-term vectors from a recursive majority
// expansion and checks results in order through a scoreboard queue.
module tb_cla_nl_combine;
  localparam int NBIT = 4;
  localparam int NNL  = 56;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_nl_combine_if #(.NBIT(NBIT), .NNL(NNL), .CNT_W(8)) bus ();
  cla_nl_combine_if #(.NBIT(NBIT), .NNL(NNL), .CNT_W(2)) bus2 ();

  cla_nl_combine #(.NBIT(NBIT), .NNL(NNL), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  cla_nl_combine #(.NBIT(NBIT), .NNL(NNL), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       mm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // c_{j+1} = a_j b_j ^ a_j c_j ^ b_j c_j, expanded recursively into single products.
  function automatic logic [55:0] gen_terms(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic        prev[$];
    logic        cur[$];
    logic [55:0] t;
    int          off;
    t = '0;
    off = 0;
    prev.push_back(c);
    for (int j = 0; j < 4; j++) begin
      cur.delete();
      cur.push_back(a[j] & b[j]);
      foreach (prev[k]) cur.push_back(a[j] & prev[k]);
      foreach (prev[k]) cur.push_back(b[j] & prev[k]);
      foreach (cur[k]) t[off+k] = cur[k];
      off += cur.size();
      prev = cur;
    end
    return t;
  endfunction

  // good=0 means all terms forced to zero: only carry-in survives, in bit 0.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic c, input bit good);
    exp_t       e;
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + {4'b0, c};
    if (good) begin
      e.sum = r[3:0]; e.cout = r[4]; e.mm = 1'b0;
    end else begin
      e.sum = a ^ b ^ {3'b0, c}; e.cout = 1'b0; e.mm = ({1'b0, e.sum} != r);
    end
    return e;
  endfunction

  // Called at posedge+1; drives one cycle, scores any delivery, returns at next posedge+1.
  task automatic run_cycle(input bit v, input logic [3:0] a, input logic [3:0] b, input logic c,
                           input bit good, input bit ordy, output bit acc);
    exp_t e;
    bus.in_valid = v; bus.a = a; bus.b = b; bus.c = c;
    bus.n = good ? gen_terms(a, b, c) : '0;
    bus.out_ready = ordy;
    #1;
    acc = v && bus.in_ready;
    if (bus.out_valid && ordy) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra got sum=%h cout=%b mm=%b required no output", bus.sum, bus.cout, bus.mismatch);
      end else begin
        e = sb.pop_front();
        if ({bus.mismatch, bus.cout, bus.sum} !== {e.mm, e.cout, e.sum}) begin
          n_err++;
          $display("FAIL result got mm=%b cout=%b sum=%h required mm=%b cout=%b sum=%h",
                   bus.mismatch, bus.cout, bus.sum, e.mm, e.cout, e.sum);
        end
      end
    end
    if (acc) sb.push_back(model(a, b, c, good));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int k = 0;
    while ((sb.size() != 0 || bus.out_valid) && k < 20) begin
      run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, acc);
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.mismatch, bus.err_sticky, bus.err_cnt} !==
        {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset got ov=%b ir=%b sum=%h co=%b mm=%b st=%b cnt=%0d", bus.out_valid, bus.in_ready,
               bus.sum, bus.cout, bus.mismatch, bus.err_sticky, bus.err_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_t1();
    bus.in_valid = 1'b1; bus.a = 4'hF; bus.b = 4'h1; bus.c = 1'b0;
    bus.n = gen_terms(4'hF, 4'h1, 1'b0); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t1_early got ov=%b required 0", bus.out_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.mismatch} !== {1'b1, 4'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL t1 got ov=%b sum=%h co=%b mm=%b required 1 0 1 0", bus.out_valid, bus.sum, bus.cout, bus.mismatch);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t1_dup got ov=%b required 0", bus.out_valid); end
  endtask

  task automatic test_t2();
    bus.in_valid = 1'b1; bus.a = 4'h1; bus.b = 4'h1; bus.c = 1'b0; bus.n = '0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.mismatch} !== {1'b1, 4'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL t2 got ov=%b sum=%h co=%b mm=%b required 1 0 0 1", bus.out_valid, bus.sum, bus.cout, bus.mismatch);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.err_sticky, bus.err_cnt} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL t2_cnt got st=%b cnt=%0d required 1 1", bus.err_sticky, bus.err_cnt);
    end
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    n_cmp++;
    if ({bus.err_sticky, bus.err_cnt} !== {1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL t2_clr got st=%b cnt=%0d required 0 0", bus.err_sticky, bus.err_cnt);
    end
  endtask

  task automatic test_exhaustive();
    bit acc;
    int stalls = 0;
    for (int i = 0; i < 512; i++) begin
      int tries = 0;
      do begin
        run_cycle(1'b1, i[3:0], i[7:4], i[8], 1'b1, 1'b1, acc);
        tries++;
        if (!acc) stalls++;
      end while (!acc && tries < 4);
    end
    drain();
    n_cmp++;
    if (stalls != 0) begin n_err++; $display("FAIL t3_stall got %0d stalls required 0", stalls); end
    n_cmp++;
    if (bus.err_cnt !== 8'd0) begin n_err++; $display("FAIL t3_cnt got %0d required 0", bus.err_cnt); end
  endtask

  task automatic test_backpressure();
    bit   acc;
    exp_t e;
    bit   exp_acc [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] va [3] = '{4'h3, 4'hF, 4'h8};
    logic [3:0] vb [3] = '{4'h5, 4'hF, 4'h7};
    logic       vc [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      int idx = (k < 2) ? k : 2;
      run_cycle(1'b1, va[idx], vb[idx], vc[idx], 1'b1, 1'b0, acc);
      n_cmp++;
      if (acc !== exp_acc[idx]) begin n_err++; $display("FAIL t4_accept cyc %0d got %b required %b", k, acc, exp_acc[idx]); end
      if (k >= 2) begin
        e = sb[0];
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.mismatch, bus.cout, bus.sum} !== {1'b0, 1'b1, e.mm, e.cout, e.sum}) begin
          n_err++;
          $display("FAIL t4_hold cyc %0d got ir=%b ov=%b sum=%h co=%b required ir=0 ov=1 sum=%h co=%b",
                   k, bus.in_ready, bus.out_valid, bus.sum, bus.cout, e.sum, e.cout);
        end
      end
    end
    run_cycle(1'b1, va[2], vb[2], vc[2], 1'b1, 1'b1, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL t4_release got acc=%b required 1", acc); end
    drain();
  endtask

  task automatic test_saturate();
    bus2.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus2.in_valid = 1'b1; bus2.a = 4'h1; bus2.b = 4'h1; bus2.c = 1'b0; bus2.n = '0;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus2.err_sticky, bus2.err_cnt} !== {1'b1, 2'd3}) begin
      n_err++;
      $display("FAIL t5_sat got st=%b cnt=%0d required 1 3", bus2.err_sticky, bus2.err_cnt);
    end
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus2.out_valid, bus2.mismatch} !== 2'b11) begin
      n_err++;
      $display("FAIL t5_sixth got ov=%b mm=%b required 1 1", bus2.out_valid, bus2.mismatch);
    end
    bus2.clr = 1'b1;
    @(posedge clk); #1;
    bus2.clr = 1'b0;
    n_cmp++;
    if ({bus2.err_sticky, bus2.err_cnt, bus2.out_valid} !== {1'b0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL t5_clr got st=%b cnt=%0d ov=%b required 0 0 0", bus2.err_sticky, bus2.err_cnt, bus2.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bit acc;
    run_cycle(1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b1, acc);
    drain();
    run_cycle(1'b1, 4'h4, 4'h4, 1'b0, 1'b1, 1'b0, acc);
    run_cycle(1'b1, 4'h6, 4'h1, 1'b1, 1'b1, 1'b0, acc);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL t6_full got ov=%b ir=%b cnt=%0d required 1 0 1", bus.out_valid, bus.in_ready, bus.err_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.err_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL t6_rst got ov=%b ir=%b cnt=%0d required 0 1 0", bus.out_valid, bus.in_ready, bus.err_cnt);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle(1'b1, 4'h9, 4'h9, 1'b1, 1'b1, 1'b1, acc);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL t6_lat1 got ov=%b required 0", bus.out_valid); end
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, acc);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL t6_lat2 got ov=%b required 1", bus.out_valid); end
    drain();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c = 1'b0; bus.n = '0;
    bus.out_ready = 1'b1; bus.clr = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.c = 1'b0; bus2.n = '0;
    bus2.out_ready = 1'b1; bus2.clr = 1'b0;
    test_reset();
    test_t1();
    test_t2();
    test_exhaustive();
    test_backpressure();
    test_saturate();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
